// File: rtl/trigger_pkg.sv
// Shared encodings for the sequential trigger node: probe condition codes,
// capture FSM states and per-stage combine selection.
package trigger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_POST  = 2'b10,
    ST_DONE  = 2'b11
  } trig_state_t;

  localparam logic [2:0] EM_DC   = 3'b000;
  localparam logic [2:0] EM_LOW  = 3'b001;
  localparam logic [2:0] EM_HIGH = 3'b010;
  localparam logic [2:0] EM_RISE = 3'b011;
  localparam logic [2:0] EM_FALL = 3'b100;
  localparam logic [2:0] EM_ANY  = 3'b101;

  localparam logic LOGIC_AND = 1'b0;
  localparam logic LOGIC_OR  = 1'b1;

endpackage

// File: rtl/trig_det_cell.sv
// One probe channel: evaluates its level/edge condition on the delayed samples.
// o_care=0 marks a don't-care channel so the stage combiner can neutralise it.
module trig_det_cell
  import trigger_pkg::*;
(
  input  logic       i_d1,
  input  logic       i_d2,
  input  logic [2:0] i_mode,
  output logic       o_care,
  output logic       o_match
);

  always_comb begin
    o_care  = 1'b1;
    o_match = 1'b0;
    case (i_mode)
      EM_LOW:  o_match = ~i_d1;
      EM_HIGH: o_match = i_d1;
      EM_RISE: o_match = i_d1 & ~i_d2;
      EM_FALL: o_match = ~i_d1 & i_d2;
      EM_ANY:  o_match = i_d1 ^ i_d2;
      default: o_care  = 1'b0;
    endcase
  end

endmodule

// File: rtl/trigger_seq_node.sv
// Multi-stage sequential trigger with circular capture-buffer address generation,
// pre-trigger overflow tracking and a post-trigger write count.
module trigger_seq_node
  import trigger_pkg::*;
#(
  parameter  int DET_NUM    = 97,
  parameter  int SEQ_STAGES = 4,
  parameter  int ADDR_W     = 16,
  parameter  int CNT_W      = 16,
  localparam int SIDX_W     = (SEQ_STAGES > 1) ? $clog2(SEQ_STAGES) : 1,
  localparam int NS_W       = $clog2(SEQ_STAGES) + 1
) (
  input  logic                          trig_clk,
  input  logic                          trig_rst,
  input  logic                          arm,
  input  logic                          pause,
  input  logic [DET_NUM-1:0]            trig_din,
  input  logic [DET_NUM*3-1:0]          trig_edge_mode,
  input  logic [SEQ_STAGES*DET_NUM-1:0] stage_mask,
  input  logic [SEQ_STAGES-1:0]         stage_logic,
  input  logic [SEQ_STAGES*CNT_W-1:0]   stage_count,
  input  logic [NS_W-1:0]               num_stages,
  input  logic [ADDR_W-1:0]             trig_len,
  input  logic [ADDR_W-1:0]             post_len,
  output logic                          wt_ce,
  output logic                          wt_en,
  output logic [ADDR_W-1:0]             wt_addr,
  output logic                          stop_flag,
  output logic                          overflow_flag,
  output logic [ADDR_W-1:0]             stop_addr,
  output logic [1:0]                    state,
  output logic [SIDX_W-1:0]             stage_idx
);

  logic [DET_NUM-1:0] r_d1, r_d2;
  trig_state_t        r_state;
  logic [ADDR_W-1:0]  r_wt_addr, r_stop_addr, r_post_cnt;
  logic               r_overflow;
  logic [SIDX_W-1:0]  r_stage_idx;
  logic [CNT_W-1:0]   r_occ;

  logic [DET_NUM-1:0]    w_care, w_match;
  logic [SEQ_STAGES-1:0] w_stage_cond;
  logic [CNT_W-1:0]      w_stage_target [SEQ_STAGES];
  logic [NS_W-1:0]       w_ns_eff;
  logic [SIDX_W-1:0]     w_last_stage;
  logic                  w_cond, w_hit_last, w_addr_wrap, w_post_last;
  logic [ADDR_W-1:0]     w_addr_last, w_addr_next;

  genvar gi;

  generate
    for (gi = 0; gi < DET_NUM; gi++) begin : g_cell
      trig_det_cell u_cell (
        .i_d1   (r_d1[gi]),
        .i_d2   (r_d2[gi]),
        .i_mode (trig_edge_mode[gi*3 +: 3]),
        .o_care (w_care[gi]),
        .o_match(w_match[gi])
      );
    end

    // Unmasked or don't-care channels drop out: neutral 1 under AND, 0 under OR.
    for (gi = 0; gi < SEQ_STAGES; gi++) begin : g_stage
      logic [DET_NUM-1:0] w_sel;
      logic [CNT_W-1:0]   w_raw;
      assign w_sel = stage_mask[gi*DET_NUM +: DET_NUM] & w_care;
      assign w_raw = stage_count[gi*CNT_W +: CNT_W];
      assign w_stage_cond[gi] = (stage_logic[gi] == LOGIC_OR) ? |(w_sel & w_match)
                                                             : &(~w_sel | w_match);
      assign w_stage_target[gi] = (w_raw == '0) ? CNT_W'(1) : w_raw;
    end
  endgenerate

  always_comb begin
    w_ns_eff = num_stages;
    if (num_stages == '0)
      w_ns_eff = NS_W'(1);
    else if (num_stages > NS_W'(SEQ_STAGES))
      w_ns_eff = NS_W'(SEQ_STAGES);
  end

  assign w_last_stage = SIDX_W'(w_ns_eff - NS_W'(1));
  assign w_cond       = w_stage_cond[r_stage_idx];
  assign w_hit_last   = (r_occ == w_stage_target[r_stage_idx] - CNT_W'(1));
  // trig_len of 0 wraps naturally to all-ones, giving the full 2^ADDR_W depth.
  assign w_addr_last  = trig_len - ADDR_W'(1);
  assign w_addr_wrap  = (r_wt_addr == w_addr_last);
  assign w_addr_next  = w_addr_wrap ? '0 : r_wt_addr + ADDR_W'(1);
  assign w_post_last  = (r_post_cnt == post_len - ADDR_W'(1));

  always_ff @(posedge trig_clk or posedge trig_rst) begin
    if (trig_rst) begin
      r_d1 <= '0;
      r_d2 <= '0;
    end else begin
      r_d1 <= trig_din;
      r_d2 <= r_d1;
    end
  end

  always_ff @(posedge trig_clk or posedge trig_rst) begin
    if (trig_rst) begin
      r_state     <= ST_IDLE;
      r_wt_addr   <= '0;
      r_stop_addr <= '0;
      r_post_cnt  <= '0;
      r_overflow  <= 1'b0;
      r_stage_idx <= '0;
      r_occ       <= '0;
    end else if (!arm) begin
      r_state     <= ST_IDLE;
      r_wt_addr   <= '0;
      r_post_cnt  <= '0;
      r_stage_idx <= '0;
      r_occ       <= '0;
    end else if (!pause) begin
      case (r_state)
        ST_IDLE: begin
          r_state     <= ST_ARMED;
          r_wt_addr   <= '0;
          r_stop_addr <= '0;
          r_post_cnt  <= '0;
          r_overflow  <= 1'b0;
          r_stage_idx <= '0;
          r_occ       <= '0;
        end
        ST_ARMED: begin
          r_wt_addr <= w_addr_next;
          if (w_addr_wrap)
            r_overflow <= 1'b1;
          if (w_cond) begin
            if (w_hit_last) begin
              r_occ <= '0;
              if (r_stage_idx >= w_last_stage) begin
                r_stop_addr <= r_wt_addr;
                r_post_cnt  <= '0;
                r_state     <= (post_len == '0) ? ST_DONE : ST_POST;
              end else begin
                r_stage_idx <= r_stage_idx + SIDX_W'(1);
              end
            end else begin
              r_occ <= r_occ + CNT_W'(1);
            end
          end
        end
        ST_POST: begin
          r_wt_addr  <= w_addr_next;
          r_post_cnt <= r_post_cnt + ADDR_W'(1);
          if (w_post_last)
            r_state <= ST_DONE;
        end
        default: r_state <= r_state;
      endcase
    end
  end

  // Writes are gated by arm so the abort cycle never strobes a stale address.
  assign wt_ce         = (r_state == ST_ARMED) || (r_state == ST_POST);
  assign wt_en         = wt_ce & arm & ~pause;
  assign wt_addr       = r_wt_addr;
  assign stop_flag     = (r_state == ST_DONE);
  assign overflow_flag = r_overflow;
  assign stop_addr     = r_stop_addr;
  assign state         = r_state;
  assign stage_idx     = r_stage_idx;

endmodule
